// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Helpers work at the widest legal width; callers size-cast to their own width.
package seq_mult_pkg;

   localparam int MAX_W  = 64;
   localparam int MAX_PW = 2 * MAX_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

   // Negation modulo 2^MAX_W keeps the low bits correct for any narrower operand.
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic neg);
      return neg ? (~x + MAX_W'(1)) : x;
   endfunction

   function automatic logic [MAX_PW-1:0] neg_val(input logic [MAX_PW-1:0] x, input logic neg);
      return neg ? (~x + MAX_PW'(1)) : x;
   endfunction

endpackage

// File: rtl/seq_mult_signfix.sv
// Sign handling around the unsigned core: operand magnitudes at capture,
// conditional two's-complement negate of the final accumulator at writeback.
module seq_mult_signfix
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic               i_signed,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   input  logic               i_neg,
   input  logic [2*WIDTH-1:0] i_acc,
   output logic [WIDTH-1:0]   o_mag_a,
   output logic [WIDTH-1:0]   o_mag_b,
   output logic               o_neg,
   output logic [2*WIDTH-1:0] o_result
);

   localparam int PW = 2 * WIDTH;

   logic w_neg_a;
   logic w_neg_b;

   assign w_neg_a  = i_signed & i_a[WIDTH-1];
   assign w_neg_b  = i_signed & i_b[WIDTH-1];

   // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
   assign o_mag_a  = WIDTH'(abs_val(MAX_W'(i_a), w_neg_a));
   assign o_mag_b  = WIDTH'(abs_val(MAX_W'(i_b), w_neg_b));
   assign o_neg    = w_neg_a ^ w_neg_b;
   assign o_result = PW'(neg_val(MAX_PW'(i_acc), i_neg));

endmodule

// File: rtl/seq_mult.sv
// Iterative shift-add WIDTH x WIDTH multiplier, unsigned or two's-complement
// per operation, with ready/valid handshakes on input and output.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | one shift-add iteration per cycle
//   DONE  | product presented, waiting for out_ready
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product,
   output logic               busy
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_mplier;
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_product;
   logic [CW-1:0]      r_cnt;
   logic               r_neg;
   logic               r_zero;

   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic               w_neg;
   logic [2*WIDTH-1:0] w_acc_nxt;
   logic [2*WIDTH-1:0] w_result;
   logic               w_start;
   logic               w_last;

   seq_mult_signfix #(
      .WIDTH (WIDTH)
   ) u_signfix (
      .i_signed (signed_mode),
      .i_a      (a),
      .i_b      (b),
      .i_neg    (r_neg),
      .i_acc    (w_acc_nxt),
      .o_mag_a  (w_mag_a),
      .o_mag_b  (w_mag_b),
      .o_neg    (w_neg),
      .o_result (w_result)
   );

   assign w_acc_nxt = r_mcand[0] ? (r_acc + r_mplier) : r_acc;
   assign w_last    = (r_cnt == LAST_CNT) || (ZERO_SKIP && r_zero);
   assign product   = r_product;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               w_start     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_last) begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_product <= '0;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_zero    <= 1'b0;
      end else if (w_start) begin
         r_mcand  <= w_mag_a;
         r_mplier <= {{WIDTH{1'b0}}, w_mag_b};
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= w_neg;
         r_zero   <= (w_mag_a == '0) || (w_mag_b == '0);
      end else if (r_state == RUN) begin
         r_acc    <= w_acc_nxt;
         r_mplier <= r_mplier << 1;
         r_mcand  <= r_mcand >> 1;
         r_cnt    <= r_cnt + CW'(1);
         // Product only changes on the final iteration so partial sums never appear.
         if (w_last) begin
            r_product <= w_result;
         end
      end
   end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult: 16-bit instances with and without zero skip,
// plus an 8-bit instance for a randomised sweep against a reference multiply.
module tb_seq_mult;

   logic clk;
   logic rst;

   // sel 0: WIDTH=16 ZERO_SKIP=1
   logic        u_iv, u_or, u_sm, u_ir, u_ov, u_busy;
   logic [15:0] u_a, u_b;
   logic [31:0] u_p;
   // sel 1: WIDTH=16 ZERO_SKIP=0
   logic        z_iv, z_or, z_sm, z_ir, z_ov, z_busy;
   logic [15:0] z_a, z_b;
   logic [31:0] z_p;
   // sel 2: WIDTH=8 ZERO_SKIP=1
   logic        e_iv, e_or, e_sm, e_ir, e_ov, e_busy;
   logic [7:0]  e_a, e_b;
   logic [15:0] e_p;

   int          n_cmp;
   int          n_bad;
   logic [31:0] sb_q[$];

   typedef struct {
      int          sel;
      logic [15:0] a;
      logic [15:0] b;
      logic        sm;
      logic [31:0] p;
      int          lat;
   } vec_t;

   vec_t vt[14];

   seq_mult #(.WIDTH(16), .ZERO_SKIP(1'b1)) dut_u (
      .clk(clk), .rst(rst), .in_valid(u_iv), .in_ready(u_ir), .a(u_a), .b(u_b),
      .signed_mode(u_sm), .out_valid(u_ov), .out_ready(u_or), .product(u_p), .busy(u_busy)
   );

   seq_mult #(.WIDTH(16), .ZERO_SKIP(1'b0)) dut_z (
      .clk(clk), .rst(rst), .in_valid(z_iv), .in_ready(z_ir), .a(z_a), .b(z_b),
      .signed_mode(z_sm), .out_valid(z_ov), .out_ready(z_or), .product(z_p), .busy(z_busy)
   );

   seq_mult #(.WIDTH(8), .ZERO_SKIP(1'b1)) dut_e (
      .clk(clk), .rst(rst), .in_valid(e_iv), .in_ready(e_ir), .a(e_a), .b(e_b),
      .signed_mode(e_sm), .out_valid(e_ov), .out_ready(e_or), .product(e_p), .busy(e_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
      logic signed [15:0] sx;
      logic signed [15:0] sy;
      logic [15:0]        r;
      if (s) begin
         sx = {{8{x[7]}}, x};
         sy = {{8{y[7]}}, y};
         r  = sx * sy;
      end else begin
         r = {8'h00, x} * {8'h00, y};
      end
      return {16'h0000, r};
   endfunction

   function automatic logic get_ov(input int sel);
      case (sel)
         0:       return u_ov;
         1:       return z_ov;
         default: return e_ov;
      endcase
   endfunction

   function automatic logic get_ir(input int sel);
      case (sel)
         0:       return u_ir;
         1:       return z_ir;
         default: return e_ir;
      endcase
   endfunction

   function automatic logic [31:0] get_p(input int sel);
      case (sel)
         0:       return u_p;
         1:       return z_p;
         default: return {16'h0000, e_p};
      endcase
   endfunction

   task automatic drive(input int sel, input logic v, input logic [15:0] xa,
                        input logic [15:0] xb, input logic xsm);
      case (sel)
         0:       begin u_iv = v; u_a = xa; u_b = xb; u_sm = xsm; end
         1:       begin z_iv = v; z_a = xa; z_b = xb; z_sm = xsm; end
         default: begin e_iv = v; e_a = xa[7:0]; e_b = xb[7:0]; e_sm = xsm; end
      endcase
   endtask

   task automatic wait_ov(input int sel, input int bound, output int lat);
      lat = 0;
      while (!get_ov(sel) && lat < bound) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // One full transaction with out_ready high; checks latency, product and hold after handshake.
   task automatic txn(input int sel, input logic [15:0] xa, input logic [15:0] xb,
                      input logic xsm, input logic [31:0] xp, input int xlat, input string nm);
      int          lat;
      logic [31:0] exp_p;
      @(negedge clk);
      check({nm, "_ready"}, 64'(get_ir(sel)), 64'd1);
      drive(sel, 1'b1, xa, xb, xsm);
      sb_q.push_back(xp);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      wait_ov(sel, 100, lat);
      check({nm, "_lat"}, 64'(lat), 64'(xlat));
      exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
      check({nm, "_prod"}, 64'(get_p(sel)), 64'(exp_p));
      @(negedge clk);
      check({nm, "_held"}, 64'(get_p(sel)), 64'(exp_p));
   endtask

   initial begin
      int          lat;
      logic [15:0] ra, rb;
      logic        rs;
      logic [31:0] exp_p;

      n_cmp = 0;
      n_bad = 0;

      vt[0]  = '{0, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16};
      vt[1]  = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 16};
      vt[2]  = '{0, 16'h8000, 16'h8000, 1'b1, 32'h40000000, 16};
      vt[3]  = '{0, 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000, 16};
      vt[4]  = '{0, 16'h0000, 16'h1234, 1'b0, 32'h00000000, 1};
      vt[5]  = '{1, 16'h0000, 16'h1234, 1'b0, 32'h00000000, 16};
      vt[6]  = '{0, 16'h7FFF, 16'h8000, 1'b1, 32'hC0008000, 16};
      vt[7]  = '{0, 16'h1234, 16'h0000, 1'b1, 32'h00000000, 1};
      vt[8]  = '{0, 16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, 16};
      vt[9]  = '{0, 16'hFFFF, 16'h8000, 1'b0, 32'h7FFF8000, 16};
      vt[10] = '{2, 16'h00FF, 16'h0002, 1'b0, 32'h000001FE, 8};
      vt[11] = '{2, 16'h0080, 16'h00FF, 1'b1, 32'h00000080, 8};
      vt[12] = '{2, 16'h00FF, 16'h00FF, 1'b1, 32'h00000001, 8};
      vt[13] = '{2, 16'h0000, 16'h0055, 1'b1, 32'h00000000, 1};

      // Reset: in_valid is asserted throughout but nothing may be captured.
      rst = 1'b1;
      drive(0, 1'b1, 16'h0005, 16'h0005, 1'b0);
      drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      drive(2, 1'b0, 16'h0000, 16'h0000, 1'b0);
      u_or = 1'b1;
      z_or = 1'b1;
      e_or = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(u_ir), 64'd1);
      check("rst_out_valid", 64'(u_ov), 64'd0);
      check("rst_busy", 64'(u_busy), 64'd0);
      check("rst_product", 64'(u_p), 64'd0);
      rst = 1'b0;
      drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      check("post_rst_busy", 64'(u_busy), 64'd0);

      for (int i = 0; i < 14; i++) begin
         txn(vt[i].sel, vt[i].a, vt[i].b, vt[i].sm, vt[i].p, vt[i].lat, $sformatf("vec%0d", i));
      end

      // Backpressure: product holds, no capture until the cycle after the handshake.
      @(negedge clk);
      u_or = 1'b0;
      drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
      sb_q.push_back(32'hFFFE0001);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b1, 16'h0002, 16'h0003, 1'b0);
      wait_ov(0, 100, lat);
      check("bp_lat", 64'(lat), 64'd16);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("bp_prod%0d", i), 64'(u_p), 64'h00000000FFFE0001);
         check($sformatf("bp_ready%0d", i), 64'(u_ir), 64'd0);
         check($sformatf("bp_valid%0d", i), 64'(u_ov), 64'd1);
         @(negedge clk);
      end
      exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
      check("bp_prod_final", 64'(u_p), 64'(exp_p));
      u_or = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_hs_ready", 64'(u_ir), 64'd1);
      check("bp_hs_busy", 64'(u_busy), 64'd0);
      check("bp_hs_valid", 64'(u_ov), 64'd0);
      sb_q.push_back(32'h00000006);
      @(posedge clk);
      @(negedge clk);
      check("bp_cap_busy", 64'(u_busy), 64'd1);
      check("bp_cap_ready", 64'(u_ir), 64'd0);
      drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      wait_ov(0, 100, lat);
      check("bp2_lat", 64'(lat), 64'd16);
      exp_p = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEADBEEF;
      check("bp2_prod", 64'(u_p), 64'(exp_p));

      // Asynchronous reset after 7 iterations discards the operation.
      @(negedge clk);
      drive(0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
      sb_q.push_back(32'hFFFE0001);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 16'h0000, 16'h0000, 1'b0);
      repeat (7) @(negedge clk);
      check("mid_busy_before", 64'(u_busy), 64'd1);
      rst = 1'b1;
      #1;
      sb_q.delete();
      check("mid_rst_valid", 64'(u_ov), 64'd0);
      check("mid_rst_product", 64'(u_p), 64'd0);
      check("mid_rst_ready", 64'(u_ir), 64'd1);
      check("mid_rst_busy", 64'(u_busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      txn(0, 16'h0003, 16'h0005, 1'b0, 32'h0000000F, 16, "after_rst");

      // Random sweep on the 8-bit instance against the reference multiply.
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = 16'($urandom_range(0, 255));
         rs = 1'($urandom);
         if ($urandom_range(0, 15) == 0) ra = 16'h0000;
         if ($urandom_range(0, 15) == 0) rb = 16'h0000;
         txn(2, ra, rb, rs, ref8(ra[7:0], rb[7:0], rs),
             ((ra == 16'h0000) || (rb == 16'h0000)) ? 1 : 8, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
